// File: rtl/branch_resolve_checker.sv
// Carries IF-time branch/loop predictions down to EX and resolves them there.
// Keeps the loop-prediction confidence counter and resolution statistics.
module branch_resolve_checker #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned CNT_WIDTH   = 32,
    parameter int unsigned CONF_THRESH = 2
) (
    input  logic                  cpu_clk,
    input  logic                  cpu_rstn,
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic                  fetch_valid,
    input  logic                  predict_taken_if,
    input  logic [ADDR_WIDTH-1:0] predict_target_if,
    input  logic                  is_loop_if,
    input  logic                  stall_if_dec,
    input  logic                  stall_dec_ex,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] pc_ex,
    input  logic                  branch_ex,
    input  logic                  branch_taken_ex,
    input  logic [ADDR_WIDTH-1:0] branch_target_ex,
    output logic                  mispredict_ex,
    output logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  predict_enable,
    output logic [CNT_WIDTH-1:0]  branch_cnt,
    output logic [CNT_WIDTH-1:0]  mispredict_cnt
);

    localparam logic [1:0] THRESH = CONF_THRESH[1:0];

    logic                  v_d;
    logic                  t_d;
    logic                  l_d;
    logic [ADDR_WIDTH-1:0] tgt_d;
    logic                  v_e;
    logic                  t_e;
    logic                  l_e;
    logic [ADDR_WIDTH-1:0] tgt_e;
    logic [1:0]            conf;

    logic evaluate;
    logic wrong;
    logic kill;
    logic fetch_pc_unused;

    // The fetch PC itself is not carried; EX supplies its own pc_ex.
    assign fetch_pc_unused = ^pc;

    // One evaluation per EX instruction: only on the cycle it leaves EX.
    assign evaluate = v_e & ~flush & ~stall_dec_ex;

    always_comb begin
        wrong = 1'b0;
        if (branch_ex) begin
            wrong = (t_e != branch_taken_ex)
                  | (t_e & branch_taken_ex & (tgt_e != branch_target_ex));
        end else begin
            wrong = t_e;
        end
    end

    assign mispredict_ex = evaluate & wrong;
    assign kill          = flush | mispredict_ex;

    always_comb begin
        redirect_pc = '0;
        if (mispredict_ex) begin
            if (branch_ex & branch_taken_ex) begin
                redirect_pc = branch_target_ex;
            end else begin
                redirect_pc = pc_ex + ADDR_WIDTH'(4);
            end
        end
    end

    assign predict_enable = (conf >= THRESH);

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            v_d   <= 1'b0;
            t_d   <= 1'b0;
            l_d   <= 1'b0;
            tgt_d <= '0;
        end else if (kill) begin
            v_d   <= 1'b0;
            t_d   <= 1'b0;
            l_d   <= 1'b0;
            tgt_d <= '0;
        end else if (!stall_if_dec) begin
            v_d   <= fetch_valid;
            t_d   <= predict_taken_if & fetch_valid;
            l_d   <= is_loop_if;
            tgt_d <= predict_target_if;
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            v_e   <= 1'b0;
            t_e   <= 1'b0;
            l_e   <= 1'b0;
            tgt_e <= '0;
        end else if (kill) begin
            v_e   <= 1'b0;
            t_e   <= 1'b0;
            l_e   <= 1'b0;
            tgt_e <= '0;
        end else if (!stall_dec_ex) begin
            v_e   <= v_d;
            t_e   <= t_d;
            l_e   <= l_d;
            tgt_e <= tgt_d;
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            conf <= 2'd0;
        end else if (evaluate & branch_ex & l_e) begin
            if (wrong) begin
                conf <= 2'd0;
            end else if (conf != 2'd3) begin
                conf <= conf + 2'd1;
            end
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else begin
            if (evaluate & branch_ex & (branch_cnt != '1)) begin
                branch_cnt <= branch_cnt + CNT_WIDTH'(1);
            end
            if (mispredict_ex & (mispredict_cnt != '1)) begin
                mispredict_cnt <= mispredict_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_checker.sv
// Self-checking bench for branch_resolve_checker against a behavioural
// model of the prediction pipeline, confidence and statistics.
module tb_branch_resolve_checker;

    localparam int AW  = 32;
    localparam int CW  = 6;
    localparam int MAX = (1 << CW) - 1;

    logic          cpu_clk = 1'b0;
    logic          cpu_rstn;
    logic [AW-1:0] pc;
    logic          fetch_valid;
    logic          predict_taken_if;
    logic [AW-1:0] predict_target_if;
    logic          is_loop_if;
    logic          stall_if_dec;
    logic          stall_dec_ex;
    logic          flush;
    logic [AW-1:0] pc_ex;
    logic          branch_ex;
    logic          branch_taken_ex;
    logic [AW-1:0] branch_target_ex;
    logic          mispredict_ex;
    logic [AW-1:0] redirect_pc;
    logic          predict_enable;
    logic [CW-1:0] branch_cnt;
    logic [CW-1:0] mispredict_cnt;

    branch_resolve_checker #(
        .ADDR_WIDTH(AW),
        .CNT_WIDTH (CW),
        .CONF_THRESH(2)
    ) dut (
        .cpu_clk          (cpu_clk),
        .cpu_rstn         (cpu_rstn),
        .pc               (pc),
        .fetch_valid      (fetch_valid),
        .predict_taken_if (predict_taken_if),
        .predict_target_if(predict_target_if),
        .is_loop_if       (is_loop_if),
        .stall_if_dec     (stall_if_dec),
        .stall_dec_ex     (stall_dec_ex),
        .flush            (flush),
        .pc_ex            (pc_ex),
        .branch_ex        (branch_ex),
        .branch_taken_ex  (branch_taken_ex),
        .branch_target_ex (branch_target_ex),
        .mispredict_ex    (mispredict_ex),
        .redirect_pc      (redirect_pc),
        .predict_enable   (predict_enable),
        .branch_cnt       (branch_cnt),
        .mispredict_cnt   (mispredict_cnt)
    );

    always #5 cpu_clk = ~cpu_clk;

    typedef struct {
        bit          v;
        bit          t;
        bit          l;
        logic [31:0] tgt;
    } ent_t;

    ent_t m_dec;
    ent_t m_ex;
    int   m_conf;
    int   m_bcnt;
    int   m_mcnt;
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic ent_t empty_ent();
        ent_t e;
        e.v = 0;
        e.t = 0;
        e.l = 0;
        e.tgt = '0;
        return e;
    endfunction

    always @(negedge cpu_clk) begin
        if (cpu_rstn) begin
            assert (stall_if_dec || !stall_dec_ex)
            else $error("illegal stall combination driven");
        end
    end

    // Reference: compare predicted next PC against the actual next PC.
    always @(negedge cpu_clk) begin
        bit          live;
        bit          act_tk;
        bit          bad;
        logic [31:0] right_pc;
        ent_t        nd;
        if (!cpu_rstn) begin
            m_dec  = empty_ent();
            m_ex   = empty_ent();
            m_conf = 0;
            m_bcnt = 0;
            m_mcnt = 0;
            chk("rst_mis", mispredict_ex, 0);
            chk("rst_redir", redirect_pc, 0);
            chk("rst_pe", predict_enable, 0);
            chk("rst_bcnt", branch_cnt, 0);
            chk("rst_mcnt", mispredict_cnt, 0);
        end else begin
            live     = m_ex.v && !flush && !stall_dec_ex;
            act_tk   = branch_ex && branch_taken_ex;
            right_pc = act_tk ? branch_target_ex : pc_ex + 32'd4;
            bad = live && ((m_ex.t != act_tk) ||
                           (m_ex.t && m_ex.tgt != branch_target_ex));
            chk("mispredict", mispredict_ex, 64'(bad));
            chk("redirect", redirect_pc, bad ? right_pc : 32'd0);
            chk("pred_en", predict_enable, 64'(m_conf >= 2));
            chk("branch_cnt", branch_cnt, 64'(m_bcnt));
            chk("mis_cnt", mispredict_cnt, 64'(m_mcnt));
            if (live && branch_ex) m_bcnt = (m_bcnt < MAX) ? m_bcnt + 1 : MAX;
            if (bad) m_mcnt = (m_mcnt < MAX) ? m_mcnt + 1 : MAX;
            if (live && branch_ex && m_ex.l)
                m_conf = bad ? 0 : ((m_conf < 3) ? m_conf + 1 : 3);
            nd.v   = fetch_valid;
            nd.t   = fetch_valid && predict_taken_if;
            nd.l   = is_loop_if;
            nd.tgt = predict_target_if;
            if (flush || bad) begin
                m_dec = empty_ent();
                m_ex  = empty_ent();
            end else begin
                if (!stall_dec_ex) m_ex = m_dec;
                if (!stall_if_dec) m_dec = nd;
            end
        end
    end

    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    function automatic logic [31:0] pick_tgt();
        case ($urandom_range(0, 2))
            0:       return 32'h0F0;
            1:       return 32'h0F4;
            default: return 32'h200;
        endcase
    endfunction

    initial begin
        cpu_rstn          = 1'b0;
        pc                = '0;
        fetch_valid       = 0;
        predict_taken_if  = 0;
        predict_target_if = '0;
        is_loop_if        = 0;
        stall_if_dec      = 0;
        stall_dec_ex      = 0;
        flush             = 0;
        pc_ex             = '0;
        branch_ex         = 0;
        branch_taken_ex   = 0;
        branch_target_ex  = '0;
        repeat (2) tick();
        cpu_rstn = 1'b1;

        // Loop branch at 0x100 predicted taken to 0x0F0, resolved the same.
        pc                = 32'h100;
        fetch_valid       = 1;
        predict_taken_if  = 1;
        predict_target_if = 32'h0F0;
        is_loop_if        = 1;
        pc_ex             = 32'h100;
        branch_ex         = 1;
        branch_taken_ex   = 1;
        branch_target_ex  = 32'h0F0;
        repeat (6) tick();
        branch_taken_ex = 0;
        tick();
        branch_taken_ex = 1;
        branch_target_ex = 32'h0F4;
        repeat (2) tick();
        branch_target_ex = 32'h0F0;
        repeat (3) tick();
        // Mispredicting branch held in EX under a 3-cycle stall.
        stall_if_dec    = 1;
        stall_dec_ex    = 1;
        branch_taken_ex = 0;
        repeat (3) tick();
        stall_if_dec = 0;
        stall_dec_ex = 0;
        tick();
        // Alias entry: predicted taken, not a branch, with and without flush.
        branch_ex = 0;
        repeat (2) tick();
        flush = 1;
        tick();
        flush = 0;
        repeat (2) tick();
        pc_ex = 32'hFFFF_FFFC;
        repeat (2) tick();

        for (int i = 0; i < 2400; i++) begin
            if (i == 800 || i == 1600) begin
                cpu_rstn = 1'b0;
                tick();
                cpu_rstn = 1'b1;
            end
            pc                = 32'h100 + 32'($urandom_range(0, 15)) * 4;
            fetch_valid       = ($urandom_range(0, 3) != 0);
            predict_taken_if  = $urandom_range(0, 1) == 1;
            predict_target_if = pick_tgt();
            is_loop_if        = ($urandom_range(0, 3) != 0);
            stall_if_dec      = ($urandom_range(0, 4) == 0);
            stall_dec_ex      = stall_if_dec && ($urandom_range(0, 1) == 1);
            flush             = ($urandom_range(0, 9) == 0);
            pc_ex             = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC
                              : 32'h100 + 32'($urandom_range(0, 15)) * 4;
            branch_ex         = ($urandom_range(0, 3) != 0);
            branch_taken_ex   = $urandom_range(0, 1) == 1;
            branch_target_ex  = ($urandom_range(0, 3) != 0) ? m_ex.tgt
                              : pick_tgt();
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
